// File: rtl/div_unit.sv
// Multi-cycle radix-2 restoring divider, one quotient bit per clock, registered result/ready.
// Result appears WIDTH+1 edges after acceptance (2 edges for divide-by-zero); held while start_i stays high.
module div_unit #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 signed_div_i,
  input  logic [WIDTH-1:0]     opdata1_i,
  input  logic [WIDTH-1:0]     opdata2_i,
  input  logic                 start_i,
  input  logic                 annul_i,
  output logic [2*WIDTH-1:0]   result_o,
  output logic                 ready_o
);

  typedef enum logic [1:0] {IDLE, BYZERO, RUN, DONE} state_t;

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state, state_nxt;

  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   dvd;      // dividend magnitude, shifts left and collects quotient bits
  logic [WIDTH-1:0]   dvs;
  logic [WIDTH-1:0]   rem;
  logic               neg_q;
  logic               neg_r;
  logic [2*WIDTH-1:0] res_q;

  logic               op1_neg;
  logic               op2_neg;
  logic [WIDTH-1:0]   op1_mag;
  logic [WIDTH-1:0]   op2_mag;
  logic [WIDTH:0]     shifted;
  logic [WIDTH:0]     diff;
  logic               q_bit;
  logic [WIDTH-1:0]   rem_nxt;
  logic [WIDTH-1:0]   quo_fin;
  logic [WIDTH-1:0]   rem_sgn;
  logic [WIDTH-1:0]   quo_sgn;
  logic               accept;

  always_comb begin
    op1_neg = signed_div_i & opdata1_i[WIDTH-1];
    op2_neg = signed_div_i & opdata2_i[WIDTH-1];
    op1_mag = op1_neg ? (~opdata1_i + 1'b1) : opdata1_i;
    op2_mag = op2_neg ? (~opdata2_i + 1'b1) : opdata2_i;

    // Partial remainder never exceeds 2*dvs-1, so a WIDTH+1 bit subtract is enough.
    shifted = {rem, dvd[WIDTH-1]};
    diff    = shifted - {1'b0, dvs};
    q_bit   = ~diff[WIDTH];
    rem_nxt = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    quo_fin = {dvd[WIDTH-2:0], q_bit};
    rem_sgn = neg_r ? (~rem_nxt + 1'b1) : rem_nxt;
    quo_sgn = neg_q ? (~quo_fin + 1'b1) : quo_fin;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i && !annul_i) begin
          accept    = 1'b1;
          state_nxt = (opdata2_i == '0) ? BYZERO : RUN;
        end
      end
      BYZERO: state_nxt = annul_i ? IDLE : DONE;
      RUN: begin
        if (annul_i)          state_nxt = IDLE;
        else if (cnt == LAST) state_nxt = DONE;
      end
      DONE: begin
        if (annul_i || !start_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      dvd   <= '0;
      dvs   <= '0;
      rem   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      res_q <= '0;
    end else if (accept) begin
      cnt   <= '0;
      dvd   <= op1_mag;
      dvs   <= op2_mag;
      rem   <= '0;
      neg_q <= op1_neg ^ op2_neg;
      neg_r <= op1_neg;
      res_q <= '0;
    end else if (state == RUN && !annul_i) begin
      cnt <= cnt + 1'b1;
      dvd <= quo_fin;
      rem <= rem_nxt;
      if (cnt == LAST) res_q <= {rem_sgn, quo_sgn};
    end
  end

  // Outputs are only exposed once DONE has been observed with start still held.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_o  <= 1'b0;
      result_o <= '0;
    end else if (state == DONE && state_nxt == DONE) begin
      ready_o  <= 1'b1;
      result_o <= res_q;
    end else begin
      ready_o  <= 1'b0;
      result_o <= '0;
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: vector table plus annul, reset and back-to-back sequences.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .signed_div_i (signed_div_i),
    .opdata1_i    (opdata1_i),
    .opdata2_i    (opdata2_i),
    .start_i      (start_i),
    .annul_i      (annul_i),
    .result_o     (result_o),
    .ready_o      (ready_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sdiv;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Start an operation, scramble operands after acceptance, measure latency,
  // verify hold for `hold` cycles, then drop start and verify the clear.
  task automatic run_op(input string name, input logic sdiv, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp, input int lat,
                        input int hold);
    int got;
    got = -1;
    @(negedge clk);
    signed_div_i = sdiv;
    opdata1_i    = a;
    opdata2_i    = b;
    start_i      = 1'b1;
    for (int e = 0; e < 45 && got < 0; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        opdata1_i    = ~a;
        opdata2_i    = 32'h0;
        signed_div_i = ~sdiv;
      end
      if (ready_o) got = e;
    end
    chk({name, "_latency"}, 64'(got), 64'(lat));
    chk({name, "_result"}, result_o, exp);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      if (h == hold - 1) begin
        chk({name, "_hold_ready"}, 64'(ready_o), 64'd1);
        chk({name, "_hold_result"}, result_o, exp);
      end
    end
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({name, "_drop_ready"}, 64'(ready_o), 64'd0);
    chk({name, "_drop_result"}, result_o, 64'd0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 32'd100,        32'd7,          64'h00000002_0000000E, 33};
    vecs[1] = '{1'b1, 32'hFFFFFFF9,   32'd2,          64'hFFFFFFFF_FFFFFFFD, 33};
    vecs[2] = '{1'b1, 32'd7,          32'hFFFFFFFE,   64'h00000001_FFFFFFFD, 33};
    vecs[3] = '{1'b1, 32'h80000000,   32'hFFFFFFFF,   64'h00000000_80000000, 33};
    vecs[4] = '{1'b0, 32'hFFFFFFFF,   32'd1,          64'h00000000_FFFFFFFF, 33};
    vecs[5] = '{1'b0, 32'd55,         32'd0,          64'h00000000_00000000, 2};
    vecs[6] = '{1'b1, 32'hFFFFFF9C,   32'hFFFFFFF9,   64'hFFFFFFFE_0000000E, 33};
    vecs[7] = '{1'b0, 32'h80000000,   32'd3,          64'h00000002_2AAAAAAA, 33};
    vecs[8] = '{1'b0, 32'hFFFFFFF9,   32'd2,          64'h00000001_7FFFFFFC, 33};
    vecs[9] = '{1'b0, 32'd5,          32'd9,          64'h00000005_00000000, 33};

    rst          = 1'b1;
    signed_div_i = 1'b0;
    opdata1_i    = '0;
    opdata2_i    = '0;
    start_i      = 1'b0;
    annul_i      = 1'b0;
    #1;
    chk("reset_ready", 64'(ready_o), 64'd0);
    chk("reset_result", result_o, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_op($sformatf("vec%0d", i), vecs[i].sdiv, vecs[i].a, vecs[i].b,
             vecs[i].exp, vecs[i].lat, 3);

    // Divide-by-zero result must persist while start stays high.
    run_op("byzero_hold", 1'b0, 32'd55, 32'd0, 64'd0, 2, 20);

    // Annul at RUN iteration 10: no result may ever appear.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      signed_div_i = 1'b0;
      opdata1_i    = 32'd100;
      opdata2_i    = 32'd7;
      start_i      = 1'b1;
      repeat (11) @(posedge clk);
      @(negedge clk);
      annul_i = 1'b1;
      start_i = 1'b0;
      @(negedge clk);
      annul_i = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (ready_o) seen++;
      end
      chk("annul_no_ready", 64'(seen), 64'd0);
    end
    run_op("after_annul", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 3);

    // Reset between edges while the result is visible clears outputs immediately.
    @(negedge clk);
    signed_div_i = 1'b0;
    opdata1_i    = 32'd100;
    opdata2_i    = 32'd7;
    start_i      = 1'b1;
    repeat (34) @(posedge clk);
    #1;
    chk("pre_rst_ready", 64'(ready_o), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_done_ready", 64'(ready_o), 64'd0);
    chk("rst_done_result", result_o, 64'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-RUN: nothing appears afterwards without a new start.
    begin
      int seen;
      seen = 0;
      @(negedge clk);
      start_i = 1'b1;
      repeat (15) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("rst_run_ready", 64'(ready_o), 64'd0);
      chk("rst_run_result", result_o, 64'd0);
      start_i = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk);
        #1;
        if (ready_o) seen++;
      end
      chk("rst_run_no_ready", 64'(seen), 64'd0);
    end

    // Back-to-back: long hold must not retrigger, then a 1-cycle gap starts a new op.
    run_op("b2b_first", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 40);
    run_op("b2b_second", 1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33, 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
